// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract datapath.
// Optional build macro used by the top: ADDSUB_SATURATE_EN.
package addsub_pkg;

    localparam int unsigned W_DEFAULT     = 16;
    localparam int unsigned CHUNK_DEFAULT = 4;

    // Operation select carried alongside each operand pair
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Pipeline depth for a given width/slice size (guarded against CHUNK=0)
    function automatic int unsigned stages_f(input int unsigned w, input int unsigned chunk);
        return (chunk == 0) ? 1 : (w / chunk);
    endfunction

    // Legal configuration: W is a non-zero multiple of CHUNK
    function automatic bit cfg_ok(input int unsigned w, input int unsigned chunk);
        return (chunk != 0) && (w >= chunk) && ((w % chunk) == 0);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit slice: {cout, s} = a + (sub ? ~b : b) + cin.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK-1:0] b_eff;
    logic [CHUNK:0]   sum;

    // Subtract is a + ~b + 1, the +1 arriving on cin of the lowest slice
    always_comb begin
        b_eff = (sub == MODE_SUB) ? ~b : b;
        sum   = (CHUNK+1)'(a) + (CHUNK+1)'(b_eff) + (CHUNK+1)'(cin);
        s     = sum[CHUNK-1:0];
        cout  = sum[CHUNK];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined unsigned W-bit add/subtract, one CHUNK-bit slice per stage,
// carry/borrow registered between stages, operands skewed in, results deskewed out.
// Build macro ADDSUB_SATURATE_EN: clamp the result on borrow (to 0) or carry (to all-ones).
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_in_valid,
    output logic         io_in_ready,
    input  logic [W-1:0] io_in_a,
    input  logic [W-1:0] io_in_b,
    input  logic         io_in_sub,
    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic [W-1:0] io_out_s,
    output logic         io_out_c
);

    localparam int unsigned STAGES = stages_f(W, CHUNK);
    localparam int unsigned TOP    = STAGES - 1;

    if (!cfg_ok(W, CHUNK)) begin : g_cfg_check
        $error("pipelined_addsub: W must be a non-zero multiple of CHUNK");
    end

    logic              adv;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] sub_q, sub_d;
    logic [STAGES-1:0] cout;
    logic [W-1:0]      s_raw;

    assign io_out_valid = valid_q[TOP];

    // Single global enable: the whole pipe advances unless the output is blocked
    always_comb begin
        adv         = io_out_ready | ~io_out_valid;
        io_in_ready = adv;
    end

    // Next-state for per-stage valid, carry and mode; bubbles shift like items
    always_comb begin
        valid_d    = valid_q;
        sub_d      = sub_q;
        c_d        = cout;
        valid_d[0] = io_in_valid;
        sub_d[0]   = io_in_sub;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            sub_d[k]   = sub_q[k-1];
        end
    end

    // Stage control registers; reset wins over the advance enable
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            c_q     <= '0;
            sub_q   <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int unsigned LO   = k * CHUNK;
        localparam int unsigned NRES = STAGES - k;

        logic [CHUNK-1:0] a_k;
        logic [CHUNK-1:0] b_k;
        logic             cin_k;
        logic             sub_k;
        logic [CHUNK-1:0] s_k;
        logic [CHUNK-1:0] s_q [NRES];
        logic [CHUNK-1:0] s_d [NRES];

        if (k == 0) begin : g_head
            // Lowest slice works straight off the input; cin seeds the +1 for subtract
            always_comb begin
                a_k   = io_in_a[LO +: CHUNK];
                b_k   = io_in_b[LO +: CHUNK];
                cin_k = io_in_sub;
                sub_k = io_in_sub;
            end
        end else begin : g_skew
            localparam int unsigned DEPTH = k;

            logic [CHUNK-1:0] a_q [DEPTH];
            logic [CHUNK-1:0] a_d [DEPTH];
            logic [CHUNK-1:0] b_q [DEPTH];
            logic [CHUNK-1:0] b_d [DEPTH];

            // Operand skew line so slice k meets the carry from stage k-1
            always_comb begin
                a_d    = a_q;
                b_d    = b_q;
                a_d[0] = io_in_a[LO +: CHUNK];
                b_d[0] = io_in_b[LO +: CHUNK];
                for (int i = 1; i < DEPTH; i++) begin
                    a_d[i] = a_q[i-1];
                    b_d[i] = b_q[i-1];
                end
            end

            // Operand skew registers
            always_ff @(posedge clock) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            // Slice inputs arrive aligned with the previous stage's registered carry
            always_comb begin
                a_k   = a_q[DEPTH-1];
                b_k   = b_q[DEPTH-1];
                cin_k = c_q[k-1];
                sub_k = sub_q[k-1];
            end
        end

        addsub_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (a_k),
            .b    (b_k),
            .cin  (cin_k),
            .sub  (sub_k),
            .s    (s_k),
            .cout (cout[k])
        );

        // Result deskew line: stage register plus STAGES-1-k delays
        always_comb begin
            s_d    = s_q;
            s_d[0] = s_k;
            for (int i = 1; i < NRES; i++) begin
                s_d[i] = s_q[i-1];
            end
        end

        // Result deskew registers
        always_ff @(posedge clock) begin
            if (!reset) begin
                for (int i = 0; i < NRES; i++) begin
                    s_q[i] <= '0;
                end
            end else if (adv) begin
                s_q <= s_d;
            end
        end

        assign s_raw[LO +: CHUNK] = s_q[NRES-1];
    end

    // Output flag is borrow for subtract, carry for add; optional clamp on overflow
    always_comb begin
        io_out_c = c_q[TOP] ^ sub_q[TOP];
        io_out_s = s_raw;
`ifdef ADDSUB_SATURATE_EN
        if (io_out_c) begin
            io_out_s = (sub_q[TOP] == MODE_SUB) ? '0 : '1;
        end
`endif
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: a W=16/CHUNK=4 instance (latency 4)
// and a W=5/CHUNK=5 instance (latency 1). Honours ADDSUB_SATURATE_EN if defined.
module tb_pipelined_addsub;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_s;
    logic        out_c;

    logic        d5_in_valid = 1'b0;
    logic        d5_in_ready;
    logic [4:0]  d5_in_a = '0;
    logic [4:0]  d5_in_b = '0;
    logic        d5_in_sub = 1'b1;
    logic        d5_out_valid;
    logic        d5_out_ready = 1'b1;
    logic [4:0]  d5_out_s;
    logic        d5_out_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    pipelined_addsub #(.W(16), .CHUNK(4)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_in_a      (in_a),
        .io_in_b      (in_b),
        .io_in_sub    (in_sub),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_s     (out_s),
        .io_out_c     (out_c)
    );

    pipelined_addsub #(.W(5), .CHUNK(5)) u_dut5 (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (d5_in_valid),
        .io_in_ready  (d5_in_ready),
        .io_in_a      (d5_in_a),
        .io_in_b      (d5_in_b),
        .io_in_sub    (d5_in_sub),
        .io_out_valid (d5_out_valid),
        .io_out_ready (d5_out_ready),
        .io_out_s     (d5_out_s),
        .io_out_c     (d5_out_c)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] exp_s;
        logic [15:0] exp_s_sat;
        logic        exp_c;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Independent reference: {flag, result}
    function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [16:0] r;
        if (sub) begin
            r[15:0] = a - b;
            r[16]   = (a < b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
`ifdef ADDSUB_SATURATE_EN
        if (r[16]) r[15:0] = sub ? 16'h0000 : 16'hFFFF;
`endif
        return r;
    endfunction

    logic [15:0] st_a   [8];
    logic [15:0] st_b   [8];
    logic        st_sub [8];
    logic [16:0] exp_q [$];

    initial begin
        int lat;
        int sent;
        int recvd;
        int cyc;
        int stale;
        logic        prev_stall;
        logic [15:0] prev_s;
        logic        prev_c;
        logic [16:0] exp;
        logic [4:0]  ea;
        logic [4:0]  eb;
        logic [4:0]  es;
        logic        ec;

        vecs[0] = '{16'h1234, 16'h0234, 1'b1, 16'h1000, 16'h1000, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h5555, 16'h5555, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0};
        vecs[5] = '{16'h0010, 16'h0001, 1'b1, 16'h000F, 16'h000F, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0};
        vecs[8] = '{16'h1000, 16'h2000, 1'b1, 16'hF000, 16'h0000, 1'b1};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0};

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_s", 32'(out_s), 32'd0);
        check("reset_out_c", 32'(out_c), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_d5_out_valid", 32'(d5_out_valid), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed single transactions: latency and result
        for (int i = 0; i < NVEC; i++) begin
            in_a      = vecs[i].a;
            in_b      = vecs[i].b;
            in_sub    = vecs[i].sub;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clock);
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
`ifdef ADDSUB_SATURATE_EN
            check($sformatf("vec%0d_s", i), 32'(out_s), 32'(vecs[i].exp_s_sat));
`else
            check($sformatf("vec%0d_s", i), 32'(out_s), 32'(vecs[i].exp_s));
`endif
            check($sformatf("vec%0d_c", i), 32'(out_c), 32'(vecs[i].exp_c));
            @(negedge clock);
        end

        // Back-to-back stream with a 3-cycle downstream stall
        for (int i = 0; i < 8; i++) begin
            st_a[i]   = 16'($urandom);
            st_b[i]   = 16'($urandom);
            st_sub[i] = 1'($urandom_range(0, 1));
        end
        st_a[2] = 16'h0003; st_b[2] = 16'h0004; st_sub[2] = 1'b1;
        st_a[5] = 16'hF000; st_b[5] = 16'h1000; st_sub[5] = 1'b0;
        sent = 0;
        recvd = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_s = '0;
        prev_c = 1'b0;
        while (recvd < 8 && cyc < 200) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a   = st_a[sent];
                in_b   = st_b[sent];
                in_sub = st_sub[sent];
            end
            #4;
            if (prev_stall) begin
                check($sformatf("stall_hold_valid_c%0d", cyc), 32'(out_valid), 32'd1);
                check($sformatf("stall_hold_s_c%0d", cyc), 32'(out_s), 32'(prev_s));
                check($sformatf("stall_hold_c_c%0d", cyc), 32'(out_c), 32'(prev_c));
            end
            if (!out_ready && out_valid)
                check($sformatf("stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model16(in_a, in_b, in_sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("stream_unexpected_out%0d", recvd), 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check($sformatf("stream_item%0d", recvd), 32'({out_c, out_s}), 32'(exp));
                end
                recvd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_s = out_s;
            prev_c = out_c;
            @(negedge clock);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_recvd_count", 32'(recvd), 32'd8);
        check("stream_leftover", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clock);
        check("stream_drained", 32'(out_valid), 32'd0);

        // Reset with three items in flight
        for (int i = 0; i < 3; i++) begin
            in_a = 16'h1111 * 16'(i + 1);
            in_b = 16'h0101;
            in_sub = 1'b0;
            in_valid = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_s", 32'(out_s), 32'd0);
        check("midrst_out_c", 32'(out_c), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        check("midrst_no_stale", 32'(stale), 32'd0);

        // Exhaustive 5-bit subtract on the single-stage instance, latency 1
        for (int j = 0; j <= 1024; j++) begin
            if (j < 1024) begin
                d5_in_valid = 1'b1;
                d5_in_a = 5'(j >> 5);
                d5_in_b = 5'(j);
            end else begin
                d5_in_valid = 1'b0;
            end
            #4;
            if (j > 0) begin
                ea = 5'((j - 1) >> 5);
                eb = 5'(j - 1);
                es = ea - eb;
                ec = (ea < eb);
`ifdef ADDSUB_SATURATE_EN
                if (ec) es = 5'd0;
`endif
                check($sformatf("d5_sub_%0d_%0d", ea, eb),
                      32'({d5_out_valid, d5_out_c, d5_out_s}), 32'({1'b1, ec, es}));
            end
            @(negedge clock);
        end
        check("d5_drained", 32'(d5_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the team's single-cycle 5-bit full subtractor.
- Unsigned W-bit add/subtract, split into CHUNK-bit slices, one slice per pipeline stage with the carry/borrow registered between stages.
- Valid/ready handshake on both sides.
- Sits in the trig datapath where wide (16–32 bit) angle/residue subtraction must close timing at the pipelined clock rate.

Parameters:
- W, 16, operand/result width in bits.
- CHUNK, 4, bits processed per stage; W must be a multiple of CHUNK.
- STAGES, W/CHUNK, derived; pipeline depth and latency in cycles.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (reset==0 clears state at the clock edge).
- io_in_valid  in  1  input operands valid.
- io_in_ready  out  1  block accepts the input this cycle.
- io_in_a  in  W  minuend / addend A.
- io_in_b  in  W  subtrahend / addend B.
- io_in_sub  in  1  1 = A−B, 0 = A+B.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  downstream accepts the result.
- io_out_s  out  W  result, modulo 2^W.
- io_out_c  out  1  sub: borrow (1 when A<B); add: carry-out.

Behaviour:
- Global pipeline enable: adv = io_out_ready | ~io_out_valid.
  - io_in_ready = adv (combinational).
  - All stage registers update only when adv=1.
- Transfer in on io_in_valid & io_in_ready; transfer out on io_out_valid & io_out_ready.
- Stage k (0..STAGES-1) computes slice k: {c_k, s_k} = a_k ± b_k ± cin_k.
  - Sub is implemented as a + ~b + 1.
  - cin_0 = io_in_sub. cin_k = registered carry from stage k-1.
  - Each stage registers its carry and the sub flag.
- Operand skew: slice k of a, b enters through k delay registers, so it arrives together with its carry.
- Result deskew: slice k of s passes through STAGES-1-k delay registers; all slices emerge aligned.
- Latency: exactly STAGES cycles from the accepting edge to io_out_valid, with no stalls in between.
- Per-stage valid bit shifts with adv. Bubbles are not collapsed.
- io_out_c:
  - sub: ~carry of the top stage (borrow).
  - add: carry of the top stage.
- Stall: while adv=0, all data and valid registers hold; io_out_s and io_out_c stay stable while io_out_valid=1 and io_out_ready=0.
- Reset (reset==0):
  - All valid bits clear, so io_out_valid=0.
  - Data registers clear to 0, so io_out_s=0 and io_out_c=0.
  - io_in_ready=1 from the first cycle after reset, since adv=1.
  - Reset mid-operation discards all in-flight items; none appear after reset.
  - Reset has priority over adv.
- STAGES=1 degenerates to a registered W-bit add/sub with latency 1.
- Boundary results:
  - A==B, sub: s=0, c=0.
  - 0−1: s=all-ones, c=1.
  - all-ones+1: s=0, c=1.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - Output stage clamps the result: sub with borrow → io_out_s=0; add with carry → io_out_s=all-ones.
  - io_out_c still reports the unclamped borrow/carry.
  - Clamp logic is combinational at the output; latency is unchanged.
- Undefined: modulo-2^W wrap result only; no clamp logic is present.

Decomposition:
- Shared package (addsub_pkg):
  - Defaults for W and CHUNK.
  - Derived STAGES function.
  - Elaboration check that W % CHUNK == 0 (fails otherwise).
  - Mode encoding constants MODE_ADD=0, MODE_SUB=1.
- Sub-module addsub_slice: combinational CHUNK-bit a ± b + cin → {cout, s}.
  - Instantiated STAGES times.
  - The top module owns all registers, skew/deskew and handshake.

Test Plan (W=16, CHUNK=4, latency 4):
- Sub 0x1234−0x0234, out_ready=1 → 4 cycles later s=0x1000, c=0.
- Sub 0x0000−0x0001 → s=0xFFFF, c=1; with ADDSUB_SATURATE_EN → s=0x0000, c=1.
- Add 0xFFFF+0x0001 → s=0x0000, c=1; with ADDSUB_SATURATE_EN → s=0xFFFF, c=1.
- Stream 8 back-to-back random ops (mixed add/sub):
  - Hold out_ready=0 for 3 cycles mid-stream → io_in_ready drops, output holds stable.
  - All 8 results arrive in order and match the reference model; no loss or duplication.
- Reset mid-stream with 3 items in flight → next cycle io_out_valid=0, s=0, c=0, io_in_ready=1; no stale results ever emerge.
- Rebuild with W=5, CHUNK=5 (STAGES=1) → exhaustive 5-bit sub matches a−b mod 32 with borrow, latency 1.
